// File: rtl/sprite_cmp_pkg.sv
// Shared definitions for the sprite scan comparator: default register field
// positions, the scan FSM encoding and a width helper.
package sprite_cmp_pkg;

    localparam int REG_W_DEF    = 32;
    localparam int COORD_W_DEF  = 10;
    localparam int X_LO_DEF     = 19;
    localparam int Y_LO_DEF     = 9;
    localparam int ACT_BIT_DEF  = 29;
    localparam int SPR_SIZE_DEF = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // ceil(log2(n)) but never below 1, so a one-entry index still has a bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sprite_box_cmp.sv
// Single-sprite hit test: does the sprite's square box cover the pixel?
// Box ends are formed one bit wider than the coordinates so a sprite placed
// near the right or bottom screen edge does not wrap around to column 0.
module sprite_box_cmp
    import sprite_cmp_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int COORD_W  = COORD_W_DEF,
    parameter int X_LO     = X_LO_DEF,
    parameter int Y_LO     = Y_LO_DEF,
    parameter int ACT_BIT  = ACT_BIT_DEF,
    parameter int SPR_SIZE = SPR_SIZE_DEF
) (
    input  logic [REG_W-1:0]   sprite,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    output logic               hit
);

    logic [COORD_W:0] sx;
    logic [COORD_W:0] sy;
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;
    logic [COORD_W:0] px_w;
    logic [COORD_W:0] py_w;

    assign sx    = {1'b0, sprite[X_LO +: COORD_W]};
    assign sy    = {1'b0, sprite[Y_LO +: COORD_W]};
    assign x_end = sx + (COORD_W+1)'(SPR_SIZE);
    assign y_end = sy + (COORD_W+1)'(SPR_SIZE);
    assign px_w  = {1'b0, px};
    assign py_w  = {1'b0, py};

    assign hit = sprite[ACT_BIT]
                 && (px_w >= sx) && (px_w < x_end)
                 && (py_w >= sy) && (py_w < y_end);

endmodule

// File: rtl/sprite_scan_comparator.sv
// Time-multiplexed sprite hit detector. A start latches the pixel, then the
// sprite registers are scanned LANES at a time; results land atomically with
// a one-cycle done pulse.
// Optional build macro SPRITE_SCAN_STICKY_EN: results OR into the previous
// hit vector (accumulating until clr) instead of replacing it.
module sprite_scan_comparator
    import sprite_cmp_pkg::*;
#(
    parameter int N        = 31,
    parameter int LANES    = 1,
    parameter int REG_W    = REG_W_DEF,
    parameter int COORD_W  = COORD_W_DEF,
    parameter int X_LO     = X_LO_DEF,
    parameter int Y_LO     = Y_LO_DEF,
    parameter int ACT_BIT  = ACT_BIT_DEF,
    parameter int SPR_SIZE = SPR_SIZE_DEF,
    localparam int IDX_W   = clog2_min1(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*REG_W-1:0]   regs_flat,
    input  logic [2*COORD_W-1:0] check,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 clr,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         hit_vec,
    output logic                 hit_any,
    output logic [IDX_W-1:0]     first_idx
);

    localparam int BEATS  = (N + LANES - 1) / LANES;
    localparam int BEAT_W = clog2_min1(BEATS);

    scan_state_t        state;
    scan_state_t        state_next;
    logic [BEAT_W-1:0]  beat;
    logic               last_beat;
    logic [COORD_W-1:0] scan_x;
    logic [COORD_W-1:0] scan_y;
    logic [N-1:0]       shadow;
    logic [N-1:0]       shadow_next;
    logic [N-1:0]       result_vec;
    logic [REG_W-1:0]   lane_reg [LANES];
    logic [LANES-1:0]   lane_hit;

    assign last_beat = (beat == BEAT_W'(BEATS - 1));

`ifdef SPRITE_SCAN_STICKY_EN
    assign result_vec = hit_vec | shadow;
`else
    assign result_vec = shadow;
`endif

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] v);
        lowest_set = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    // Route this beat's sprites onto the lanes; slots past N stay zero (inactive)
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_reg[l] = '0;
            for (int s = 0; s < N; s++) begin
                if (s == int'(beat) * LANES + l) lane_reg[l] = regs_flat[s*REG_W +: REG_W];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sprite_box_cmp #(
            .REG_W   (REG_W),
            .COORD_W (COORD_W),
            .X_LO    (X_LO),
            .Y_LO    (Y_LO),
            .ACT_BIT (ACT_BIT),
            .SPR_SIZE(SPR_SIZE)
        ) u_cmp (
            .sprite(lane_reg[l]),
            .px    (scan_x),
            .py    (scan_y),
            .hit   (lane_hit[l])
        );
    end

    // Merge the lane results into the shadow slots owned by the current beat
    always_comb begin
        shadow_next = shadow;
        for (int s = 0; s < N; s++) begin
            if (s / LANES == int'(beat)) shadow_next[s] = lane_hit[s % LANES];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next-state logic and busy flag
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN: begin
                if (abort)          state_next = IDLE;
                else if (last_beat) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Scan datapath: pixel latch, beat counter, shadow and published results
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat      <= '0;
            scan_x    <= '0;
            scan_y    <= '0;
            shadow    <= '0;
            done      <= 1'b0;
            hit_vec   <= '0;
            hit_any   <= 1'b0;
            first_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        scan_x <= check[2*COORD_W-1:COORD_W];
                        scan_y <= check[COORD_W-1:0];
                        beat   <= '0;
                        shadow <= '0;
                    end
                end
                SCAN: begin
                    if (!abort) begin
                        shadow <= shadow_next;
                        beat   <= beat + BEAT_W'(1);
                    end
                end
                DONE:    done <= 1'b1;
                default: done <= 1'b0;
            endcase

            if (clr) begin
                hit_vec   <= '0;
                hit_any   <= 1'b0;
                first_idx <= '0;
            end else if (state == DONE) begin
                hit_vec   <= result_vec;
                hit_any   <= |result_vec;
                first_idx <= lowest_set(result_vec);
            end
        end
    end

endmodule

// File: tb/tb_sprite_scan_comparator.sv
// Directed self-checking bench for sprite_scan_comparator. Instance dut_a uses
// the default N=31, LANES=1; dut_b uses LANES=4.
module tb_sprite_scan_comparator;

    localparam int N     = 31;
    localparam int REG_W = 32;

    logic             clk;
    logic             reset;
    logic [N*REG_W-1:0] regs_flat;
    logic [19:0]      check;
    logic             start_a;
    logic             start_b;
    logic             abort;
    logic             clr;

    logic             busy_a, done_a, hit_any_a;
    logic [N-1:0]     hit_vec_a;
    logic [4:0]       first_idx_a;
    logic             busy_b, done_b, hit_any_b;
    logic [N-1:0]     hit_vec_b;
    logic [4:0]       first_idx_b;

    int checks;
    int failures;
    int cnt;
    int first_done;
    int done_count;

    sprite_scan_comparator #(.N(N), .LANES(1)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .regs_flat(regs_flat),
        .check    (check),
        .start    (start_a),
        .abort    (abort),
        .clr      (clr),
        .busy     (busy_a),
        .done     (done_a),
        .hit_vec  (hit_vec_a),
        .hit_any  (hit_any_a),
        .first_idx(first_idx_a)
    );

    sprite_scan_comparator #(.N(N), .LANES(4)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .regs_flat(regs_flat),
        .check    (check),
        .start    (start_b),
        .abort    (abort),
        .clr      (clr),
        .busy     (busy_b),
        .done     (done_b),
        .hit_vec  (hit_vec_b),
        .hit_any  (hit_any_b),
        .first_idx(first_idx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mkSprite(input int x, input int y, input bit act);
        return {2'b00, act, 10'(x), 10'(y), 9'd0};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Latch pixel and pulse start for one edge; returns #1 after the start edge
    task automatic applyStimulus(input int px, input int py, input bit use_b);
        check = {10'(px), 10'(py)};
        if (use_b) start_b = 1'b1;
        else       start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Count edges after the start edge until done; -1 on timeout
    task automatic waitDone(input bit use_b, output int edges);
        edges = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if ((use_b ? done_b : done_a) === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic pulseClear();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        regs_flat = '0;
        check     = '0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        abort     = 1'b0;
        clr       = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 64'(busy_a), 64'd0);
        checkOutput("rst_done", 64'(done_a), 64'd0);
        checkOutput("rst_hit_vec", 64'(hit_vec_a), 64'd0);
        checkOutput("rst_hit_any", 64'(hit_any_a), 64'd0);
        checkOutput("rst_first_idx", 64'(first_idx_a), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic hit on sprite 3; sprite 9 covers the pixel but is inactive
        regs_flat[3*REG_W +: REG_W] = mkSprite(100, 50, 1'b1);
        regs_flat[9*REG_W +: REG_W] = mkSprite(100, 50, 1'b0);
        applyStimulus(110, 60, 1'b0);
        checkOutput("t1_busy", 64'(busy_a), 64'd1);
        waitDone(1'b0, cnt);
        checkOutput("t1_latency", 64'(cnt), 64'd32);
        checkOutput("t1_hit_vec", 64'(hit_vec_a), 64'h8);
        checkOutput("t1_hit_any", 64'(hit_any_a), 64'd1);
        checkOutput("t1_first_idx", 64'(first_idx_a), 64'd3);
        @(posedge clk); #1;
        checkOutput("t1_done_pulse", 64'(done_a), 64'd0);
        checkOutput("t1_busy_after", 64'(busy_a), 64'd0);

        // Box edges
        pulseClear();
        applyStimulus(119, 69, 1'b0);
        waitDone(1'b0, cnt);
        checkOutput("t2_far_corner", 64'(hit_vec_a), 64'h8);
        pulseClear();
        applyStimulus(120, 60, 1'b0);
        waitDone(1'b0, cnt);
        checkOutput("t2_right_out", 64'(hit_vec_a), 64'h0);
        checkOutput("t2_right_any", 64'(hit_any_a), 64'd0);
        checkOutput("t2_right_idx", 64'(first_idx_a), 64'd0);
        pulseClear();
        applyStimulus(99, 60, 1'b0);
        waitDone(1'b0, cnt);
        checkOutput("t2_left_out", 64'(hit_vec_a), 64'h0);
        pulseClear();
        regs_flat[3*REG_W +: REG_W] = mkSprite(1015, 50, 1'b1);
        applyStimulus(1020, 60, 1'b0);
        waitDone(1'b0, cnt);
        checkOutput("t2_no_wrap", 64'(hit_vec_a), 64'h8);

        // Four lanes: sprites 5 and 17 overlap the pixel
        regs_flat = '0;
        regs_flat[5*REG_W +: REG_W]  = mkSprite(200, 300, 1'b1);
        regs_flat[17*REG_W +: REG_W] = mkSprite(195, 295, 1'b1);
        applyStimulus(205, 310, 1'b1);
        waitDone(1'b1, cnt);
        checkOutput("t3_latency", 64'(cnt), 64'd9);
        checkOutput("t3_hit_vec", 64'(hit_vec_b), 64'h20020);
        checkOutput("t3_first_idx", 64'(first_idx_b), 64'd5);
        checkOutput("t3_a_untouched", 64'(hit_vec_a), 64'h8);

        // Second start mid-scan is ignored
        regs_flat = '0;
        regs_flat[3*REG_W +: REG_W] = mkSprite(100, 50, 1'b1);
        applyStimulus(110, 60, 1'b0);
        first_done = -1;
        done_count = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 10) start_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0;
            if (done_a === 1'b1) begin
                done_count++;
                if (first_done < 0) first_done = i;
            end
        end
        checkOutput("t4_restart_latency", 64'(first_done), 64'd32);
        checkOutput("t4_restart_count", 64'(done_count), 64'd1);

        // Abort keeps previous outputs
        applyStimulus(300, 300, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("t4_abort_busy", 64'(busy_a), 64'd0);
        done_count = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done_a === 1'b1) done_count++;
        end
        checkOutput("t4_abort_no_done", 64'(done_count), 64'd0);
        checkOutput("t4_abort_kept", 64'(hit_vec_a), 64'h8);
        checkOutput("t4_abort_kept_idx", 64'(first_idx_a), 64'd3);

        // Reset mid-scan
        applyStimulus(110, 60, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("t5_rst_busy", 64'(busy_a), 64'd0);
        checkOutput("t5_rst_hit_vec", 64'(hit_vec_a), 64'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        done_count = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done_a === 1'b1) done_count++;
        end
        checkOutput("t5_rst_no_done", 64'(done_count), 64'd0);

        // clr coincident with the result update
        applyStimulus(110, 60, 1'b0);
        repeat (31) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checkOutput("t5_clr_done", 64'(done_a), 64'd1);
        checkOutput("t5_clr_hit_vec", 64'(hit_vec_a), 64'h0);
        checkOutput("t5_clr_hit_any", 64'(hit_any_a), 64'd0);

        // Two scans: replace or accumulate depending on build
        regs_flat = '0;
        regs_flat[2*REG_W +: REG_W] = mkSprite(10, 10, 1'b1);
        regs_flat[7*REG_W +: REG_W] = mkSprite(400, 400, 1'b1);
        applyStimulus(15, 15, 1'b0);
        waitDone(1'b0, cnt);
        checkOutput("t6_scan1", 64'(hit_vec_a), 64'h4);
        applyStimulus(405, 405, 1'b0);
        waitDone(1'b0, cnt);
`ifdef SPRITE_SCAN_STICKY_EN
        checkOutput("t6_scan2", 64'(hit_vec_a), 64'h84);
        checkOutput("t6_scan2_idx", 64'(first_idx_a), 64'd2);
`else
        checkOutput("t6_scan2", 64'(hit_vec_a), 64'h80);
        checkOutput("t6_scan2_idx", 64'(first_idx_a), 64'd7);
`endif
        checkOutput("t6_scan2_any", 64'(hit_any_a), 64'd1);
        pulseClear();
        checkOutput("t6_clr", 64'(hit_vec_a), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
